// File: rtl/pipe_pkg.sv
// Shared types and default widths for the elastic pipeline stage and its helpers.
package pipe_pkg;

  localparam int unsigned DefDataW = 96;
  localparam int unsigned DefCtrlW = 8;
  localparam int unsigned DefCntW  = 16;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } stateT;

  typedef logic [1:0] occT;

  function automatic occT stateToOcc(stateT s);
    case (s)
      StOne:   stateToOcc = 2'd1;
      StFull:  stateToOcc = 2'd2;
      default: stateToOcc = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with increment enable; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] countQ;
  logic [CNT_W-1:0] countNext;

  always_comb begin
    countNext = countQ;
    if (inc && (countQ != {CNT_W{1'b1}})) begin
      countNext = countQ + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      countQ <= '0;
    end else begin
      countQ <= countNext;
    end
  end

  assign count = countQ;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: valid/ready handshake, optional two-entry skid, stall, flush and a
// saturating blocked-cycle counter.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned CTRL_W = DefCtrlW,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = DefCntW
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              Stall,
  input  logic              Flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  stateT             state;
  stateT             stateNext;
  logic [DATA_W-1:0] mainData;
  logic [DATA_W-1:0] mainDataNext;
  logic [CTRL_W-1:0] mainCtrl;
  logic [CTRL_W-1:0] mainCtrlNext;
  logic [DATA_W-1:0] skidData;
  logic [DATA_W-1:0] skidDataNext;
  logic [CTRL_W-1:0] skidCtrl;
  logic [CTRL_W-1:0] skidCtrlNext;

  logic mainValid;
  logic skidValid;
  logic advance;
  logic accept;
  logic readyRaw;

  assign mainValid = (state != StEmpty);
  assign skidValid = (state == StFull);
  assign advance   = mainValid & out_ready & ~Stall;

  // With a skid entry, readiness depends only on registered state, breaking the out_ready path.
  assign readyRaw  = (SKID != 0) ? ~skidValid : (~mainValid | advance);
  assign in_ready  = RESETn & readyRaw;
  assign accept    = in_valid & in_ready;

  always_comb begin
    stateNext    = state;
    mainDataNext = mainData;
    mainCtrlNext = mainCtrl;
    skidDataNext = skidData;
    skidCtrlNext = skidCtrl;

    if (Flush) begin
      // Payload is left in place; only valids and control are killed.
      stateNext    = StEmpty;
      mainCtrlNext = '0;
      skidCtrlNext = '0;
    end else begin
      case (state)
        StEmpty: begin
          if (accept) begin
            stateNext    = StOne;
            mainDataNext = in_data;
            mainCtrlNext = in_ctrl;
          end
        end
        StOne: begin
          if (advance) begin
            if (accept) begin
              mainDataNext = in_data;
              mainCtrlNext = in_ctrl;
            end else begin
              stateNext    = StEmpty;
              mainCtrlNext = '0;
            end
          end else if (accept && (SKID != 0)) begin
            stateNext    = StFull;
            skidDataNext = in_data;
            skidCtrlNext = in_ctrl;
          end
        end
        StFull: begin
          if (advance) begin
            stateNext    = StOne;
            mainDataNext = skidData;
            mainCtrlNext = skidCtrl;
            skidCtrlNext = '0;
          end
        end
        default: begin
          stateNext = StEmpty;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state    <= StEmpty;
      mainData <= '0;
      mainCtrl <= '0;
      skidData <= '0;
      skidCtrl <= '0;
    end else begin
      state    <= stateNext;
      mainData <= mainDataNext;
      mainCtrl <= mainCtrlNext;
      skidData <= skidDataNext;
      skidCtrl <= skidCtrlNext;
    end
  end

  assign out_valid = mainValid;
  assign out_data  = mainData;
  assign out_ctrl  = mainValid ? mainCtrl : '0;
  assign occupancy = stateToOcc(state);

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .CLK   (CLK),
    .RESETn(RESETn),
    .inc   (mainValid & ~advance & ~Flush),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed self-checking bench for pipe_stage_elastic: SKID=1, SKID=0 and a narrow-counter build
// share one stimulus bus.
module tb_pipe_stage_elastic;

  logic        CLK;
  logic        RESETn;
  logic        inValid;
  logic        outReady;
  logic        stall;
  logic        flush;
  logic [31:0] inData;
  logic [7:0]  inCtrl;

  logic        rdy1, vld1, rdy0, vld0, rdy4, vld4;
  logic [31:0] dat1, dat0, dat4;
  logic [7:0]  ctl1, ctl0, ctl4;
  logic [1:0]  occ1, occ0, occ4;
  logic [15:0] cnt1, cnt0;
  logic [3:0]  cnt4;

  int checks;
  int failures;

  pipe_stage_elastic #(.DATA_W(32), .CTRL_W(8), .SKID(1), .CNT_W(16)) dut1 (
    .CLK(CLK), .RESETn(RESETn), .in_valid(inValid), .in_ready(rdy1), .in_data(inData),
    .in_ctrl(inCtrl), .out_valid(vld1), .out_ready(outReady), .out_data(dat1), .out_ctrl(ctl1),
    .Stall(stall), .Flush(flush), .occupancy(occ1), .stall_cnt(cnt1)
  );

  pipe_stage_elastic #(.DATA_W(32), .CTRL_W(8), .SKID(0), .CNT_W(16)) dut0 (
    .CLK(CLK), .RESETn(RESETn), .in_valid(inValid), .in_ready(rdy0), .in_data(inData),
    .in_ctrl(inCtrl), .out_valid(vld0), .out_ready(outReady), .out_data(dat0), .out_ctrl(ctl0),
    .Stall(stall), .Flush(flush), .occupancy(occ0), .stall_cnt(cnt0)
  );

  pipe_stage_elastic #(.DATA_W(32), .CTRL_W(8), .SKID(1), .CNT_W(4)) dut4 (
    .CLK(CLK), .RESETn(RESETn), .in_valid(inValid), .in_ready(rdy4), .in_data(inData),
    .in_ctrl(inCtrl), .out_valid(vld4), .out_ready(outReady), .out_data(dat4), .out_ctrl(ctl4),
    .Stall(stall), .Flush(flush), .occupancy(occ4), .stall_cnt(cnt4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic reset_all();
    RESETn   = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    inData   = '0;
    inCtrl   = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESETn = 1'b1;
  endtask

  task automatic test_reset();
    reset_all();
    inValid = 1'b1; inData = 32'h5; inCtrl = 8'h3;
    tick();
    checks++;
    if ({vld1, ctl1} !== {1'b1, 8'h3}) begin
      failures++; $display("FAIL rst_preload got=%0h exp=%0h", {vld1, ctl1}, {1'b1, 8'h3});
    end
    inValid = 1'b0;
    #2 RESETn = 1'b0;
    #1;
    checks++;
    if ({vld1, ctl1, rdy1, occ1, cnt1, dat1} !== '0) begin
      failures++; $display("FAIL rst_async_dut1 got=%0h exp=0", {vld1, ctl1, rdy1, occ1, cnt1, dat1});
    end
    checks++;
    if ({vld0, ctl0, rdy0, occ0, cnt0, dat0} !== '0) begin
      failures++; $display("FAIL rst_async_dut0 got=%0h exp=0", {vld0, ctl0, rdy0, occ0, cnt0, dat0});
    end
    checks++;
    if ({vld4, ctl4, rdy4, occ4, cnt4, dat4} !== '0) begin
      failures++; $display("FAIL rst_async_dut4 got=%0h exp=0", {vld4, ctl4, rdy4, occ4, cnt4, dat4});
    end
    @(negedge CLK);
    RESETn = 1'b1;
    #1;
    checks++;
    if ({rdy1, rdy0} !== 2'b11) begin
      failures++; $display("FAIL rst_release_ready got=%b exp=11", {rdy1, rdy0});
    end
  endtask

  task automatic test_stream();
    inValid = 1'b1; outReady = 1'b1; stall = 1'b0; flush = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      inData = i; inCtrl = 8'(i);
      tick();
      checks++;
      if ({vld1, occ1, dat1} !== {1'b1, 2'd1, 32'(i)}) begin
        failures++;
        $display("FAIL stream_beat%0d got=%0h exp=%0h", i, {vld1, occ1, dat1}, {1'b1, 2'd1, 32'(i)});
      end
    end
    inValid = 1'b0;
    tick();
    checks++;
    if ({vld1, occ1} !== 3'b000) begin
      failures++; $display("FAIL stream_drain got=%0h exp=0", {vld1, occ1});
    end
  endtask

  task automatic test_backpressure();
    outReady = 1'b0; inValid = 1'b1; inData = 32'hA; inCtrl = 8'h0A;
    tick();
    checks++;
    if ({occ1, dat1, rdy1} !== {2'd1, 32'hA, 1'b1}) begin
      failures++; $display("FAIL bp_first got=%0h exp=%0h", {occ1, dat1, rdy1}, {2'd1, 32'hA, 1'b1});
    end
    inData = 32'hB; inCtrl = 8'h0B;
    tick();
    inData = 32'hC; inCtrl = 8'h0C;
    tick();
    checks++;
    if ({occ1, dat1, rdy1} !== {2'd2, 32'hA, 1'b0}) begin
      failures++; $display("FAIL bp_full got=%0h exp=%0h", {occ1, dat1, rdy1}, {2'd2, 32'hA, 1'b0});
    end
    outReady = 1'b1;
    tick();
    checks++;
    if ({occ1, dat1} !== {2'd1, 32'hB}) begin
      failures++; $display("FAIL bp_second got=%0h exp=%0h", {occ1, dat1}, {2'd1, 32'hB});
    end
    tick();
    checks++;
    if ({occ1, dat1, ctl1} !== {2'd1, 32'hC, 8'h0C}) begin
      failures++; $display("FAIL bp_third got=%0h exp=%0h", {occ1, dat1, ctl1}, {2'd1, 32'hC, 8'h0C});
    end
    inValid = 1'b0;
    tick();
    checks++;
    if ({vld1, occ1} !== 3'b000) begin
      failures++; $display("FAIL bp_empty got=%0h exp=0", {vld1, occ1});
    end
  endtask

  task automatic test_stall();
    reset_all();
    inValid = 1'b1; inData = 32'h55; inCtrl = 8'h11; outReady = 1'b1;
    tick();
    inValid = 1'b0; stall = 1'b1;
    repeat (5) tick();
    checks++;
    if ({cnt1, dat1, occ1} !== {16'd5, 32'h55, 2'd1}) begin
      failures++; $display("FAIL stall_5 got=%0h exp=%0h", {cnt1, dat1, occ1}, {16'd5, 32'h55, 2'd1});
    end
    repeat (15) tick();
    checks++;
    if (cnt1 !== 16'd20) begin
      failures++; $display("FAIL stall_20 got=%0d exp=20", cnt1);
    end
    checks++;
    if (cnt4 !== 4'd15) begin
      failures++; $display("FAIL stall_saturate got=%0d exp=15", cnt4);
    end
    stall = 1'b0;
    tick();
    checks++;
    if ({occ1, cnt1} !== {2'd0, 16'd20}) begin
      failures++; $display("FAIL stall_release got=%0h exp=%0h", {occ1, cnt1}, {2'd0, 16'd20});
    end
  endtask

  task automatic test_flush();
    outReady = 1'b0; stall = 1'b0; inValid = 1'b1; inData = 32'h1; inCtrl = 8'hFF;
    tick();
    inData = 32'h2;
    tick();
    checks++;
    if ({occ1, ctl1} !== {2'd2, 8'hFF}) begin
      failures++; $display("FAIL flush_setup got=%0h exp=%0h", {occ1, ctl1}, {2'd2, 8'hFF});
    end
    flush = 1'b1; stall = 1'b1; inData = 32'h3;
    tick();
    checks++;
    if ({vld1, occ1, ctl1} !== '0) begin
      failures++; $display("FAIL flush_kill got=%0h exp=0", {vld1, occ1, ctl1});
    end
    checks++;
    if (dat1 !== 32'h1) begin
      failures++; $display("FAIL flush_data_kept got=%0h exp=1", dat1);
    end
    flush = 1'b0; stall = 1'b0; inValid = 1'b0; outReady = 1'b1;
    tick();
    checks++;
    if ({vld1, rdy1} !== 2'b01) begin
      failures++; $display("FAIL flush_no_ghost got=%b exp=01", {vld1, rdy1});
    end
    inValid = 1'b1; inData = 32'h9; flush = 1'b1;
    tick();
    checks++;
    if ({vld1, occ1} !== 3'b000) begin
      failures++; $display("FAIL flush_accept_drop got=%0h exp=0", {vld1, occ1});
    end
    flush = 1'b0; inValid = 1'b0;
  endtask

  task automatic test_skid0();
    reset_all();
    inValid = 1'b1; outReady = 1'b1; inData = 32'h10;
    #1;
    checks++;
    if (rdy0 !== 1'b1) begin failures++; $display("FAIL s0_rdy_empty got=%b exp=1", rdy0); end
    tick();
    checks++;
    if ({vld0, occ0, dat0} !== {1'b1, 2'd1, 32'h10}) begin
      failures++; $display("FAIL s0_beat10 got=%0h exp=%0h", {vld0, occ0, dat0}, {1'b1, 2'd1, 32'h10});
    end
    outReady = 1'b0; inData = 32'h11;
    #1;
    checks++;
    if (rdy0 !== 1'b0) begin failures++; $display("FAIL s0_rdy_blocked got=%b exp=0", rdy0); end
    tick();
    checks++;
    if ({occ0, dat0} !== {2'd1, 32'h10}) begin
      failures++; $display("FAIL s0_hold got=%0h exp=%0h", {occ0, dat0}, {2'd1, 32'h10});
    end
    outReady = 1'b1;
    #1;
    checks++;
    if (rdy0 !== 1'b1) begin failures++; $display("FAIL s0_rdy_advance got=%b exp=1", rdy0); end
    tick();
    checks++;
    if ({occ0, dat0} !== {2'd1, 32'h11}) begin
      failures++; $display("FAIL s0_beat11 got=%0h exp=%0h", {occ0, dat0}, {2'd1, 32'h11});
    end
    stall = 1'b1; inData = 32'h12;
    #1;
    checks++;
    if (rdy0 !== 1'b0) begin failures++; $display("FAIL s0_rdy_stall got=%b exp=0", rdy0); end
    tick();
    stall = 1'b0;
    tick();
    checks++;
    if ({occ0, dat0} !== {2'd1, 32'h12}) begin
      failures++; $display("FAIL s0_beat12 got=%0h exp=%0h", {occ0, dat0}, {2'd1, 32'h12});
    end
    inValid = 1'b0;
    tick();
    checks++;
    if ({vld0, occ0} !== 3'b000) begin
      failures++; $display("FAIL s0_drain got=%0h exp=0", {vld0, occ0});
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_stall();
    test_flush();
    test_skid0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
